// File: rtl/scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_pkg
// Description : Shared constants for the hazard scoreboard (register file
//               geometry, forwarding source codes, result latencies).
// Revision    : 1.0 - initial release
// ============================================================================
package scoreboard_pkg;

    localparam int          NUM_REGS = 32;
    localparam int          REG_AW   = 5;

    localparam logic [1:0]  FWD_RF   = 2'd0;
    localparam logic [1:0]  FWD_EXE  = 2'd1;
    localparam logic [1:0]  FWD_MEM  = 2'd2;
    localparam logic [1:0]  FWD_WB   = 2'd3;

    localparam logic [1:0]  LAT_ALU  = 2'd1;
    localparam logic [1:0]  LAT_LOAD = 2'd2;

    // Anything other than an ALU latency is handled like a load.
    function automatic logic [1:0] norm_lat(input logic [1:0] lat);
        return (lat == LAT_ALU) ? LAT_ALU : LAT_LOAD;
    endfunction

endpackage : scoreboard_pkg
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
// Module      : sb_entry
// Description : Scoreboard state for one architectural register: pending
//               flag, pipeline stage of the in-flight producer, and the stage
//               at which its result becomes forwardable.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_entry
    import scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [1:0]  lat,
    input  logic        retire,
    output logic        pending,
    output logic [1:0]  stage,
    output logic [1:0]  avail
);

    logic       r_pending;
    logic [1:0] r_stage;
    logic [1:0] r_avail;

    // A new producer takes priority over a retire of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_stage   <= 2'd0;
            r_avail   <= 2'd0;
        end else if (set) begin
            r_pending <= 1'b1;
            r_stage   <= 2'd1;
            r_avail   <= norm_lat(lat);
        end else begin
            if (retire) begin
                r_pending <= 1'b0;
            end
            if (r_pending && (r_stage != 2'd3)) begin
                r_stage <= r_stage + 2'd1;
            end
        end
    end

    assign pending = r_pending;
    assign stage   = r_stage;
    assign avail   = r_avail;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : In-order issue scoreboard: detects RAW/WAW hazards, stalls
//               decode and selects operand forwarding sources.
//               Optional stall counter enabled by HAZARD_SCOREBOARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [REG_AW-1:0]      issue_src_a,
    input  logic [REG_AW-1:0]      issue_src_b,
    input  logic                   issue_use_a,
    input  logic                   issue_use_b,
    input  logic [REG_AW-1:0]      issue_dst,
    input  logic                   issue_wr,
    input  logic [1:0]             issue_lat,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_add,
    output logic [1:0]             fwd_sel_a,
    output logic [1:0]             fwd_sel_b,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic             w_pending [NUM_REGS];
    logic [1:0]       w_stage   [NUM_REGS];
    logic [1:0]       w_avail   [NUM_REGS];

    logic             w_live_a;
    logic             w_live_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_haz_waw;
    logic             w_accept;

    // Register 0 is hardwired and never tracked.
    assign w_pending[0] = 1'b0;
    assign w_stage[0]   = 2'd0;
    assign w_avail[0]   = 2'd0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
            sb_entry u_entry (
                .clk     (clk),
                .rst     (rst),
                .set     (w_accept && issue_wr && (issue_dst == REG_AW'(i))),
                .lat     (issue_lat),
                .retire  (wb_valid && (wb_add == REG_AW'(i))),
                .pending (w_pending[i]),
                .stage   (w_stage[i]),
                .avail   (w_avail[i])
            );
        end
    endgenerate

    // Hazards are evaluated on registered state only; a same-cycle
    // writeback does not unblock an issue.
    always_comb begin
        w_live_a  = issue_use_a && (issue_src_a != '0) && w_pending[issue_src_a];
        w_live_b  = issue_use_b && (issue_src_b != '0) && w_pending[issue_src_b];
        w_haz_a   = w_live_a && (w_stage[issue_src_a] < w_avail[issue_src_a]);
        w_haz_b   = w_live_b && (w_stage[issue_src_b] < w_avail[issue_src_b]);
        w_haz_waw = issue_wr && (issue_dst != '0) && w_pending[issue_dst];
        fwd_sel_a = w_live_a ? w_stage[issue_src_a] : FWD_RF;
        fwd_sel_b = w_live_b ? w_stage[issue_src_b] : FWD_RF;
    end

    assign issue_ready = !(issue_valid && (w_haz_a || w_haz_b || w_haz_waw));
    assign w_accept    = issue_valid && issue_ready;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed and random bench for hazard_scoreboard against a
//               producer-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_src_a;
    logic [4:0]  issue_src_b;
    logic        issue_use_a;
    logic        issue_use_b;
    logic [4:0]  issue_dst;
    logic        issue_wr;
    logic [1:0]  issue_lat;
    logic        wb_valid;
    logic [4:0]  wb_add;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_cycles;

    hazard_scoreboard #(.STALL_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_src_a  (issue_src_a),
        .issue_src_b  (issue_src_b),
        .issue_use_a  (issue_use_a),
        .issue_use_b  (issue_use_b),
        .issue_dst    (issue_dst),
        .issue_wr     (issue_wr),
        .issue_lat    (issue_lat),
        .wb_valid     (wb_valid),
        .wb_add       (wb_add),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each register remembers when its producer issued and how many
    // cycles it needs before the result can be forwarded.
    int  now = 0;
    bit  m_pend  [32];
    int  m_itime [32];
    int  m_need  [32];
    int  m_stall = 0;
    bit  perf_en;

    function automatic int m_stage(input int r);
        int d;
        d = now - m_itime[r];
        return (d > 3) ? 3 : d;
    endfunction

    function automatic bit m_live(input bit use_s, input int s);
        return use_s && (s != 0) && m_pend[s];
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = 0;
        if (m_live(issue_use_a, issue_src_a) && m_stage(issue_src_a) < m_need[issue_src_a]) haz = 1;
        if (m_live(issue_use_b, issue_src_b) && m_stage(issue_src_b) < m_need[issue_src_b]) haz = 1;
        if (issue_wr && issue_dst != 0 && m_pend[issue_dst]) haz = 1;
        return !(issue_valid && haz);
    endfunction

    function automatic int m_fwd(input bit use_s, input int s);
        return m_live(use_s, s) ? m_stage(s) : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs away from the clock edge and compare against the model.
    task automatic drive(input bit r, input bit v, input int sa, input bit ua,
                         input int sb, input bit ub, input int dst, input bit wr,
                         input int lat, input bit wbv, input int wba);
        @(negedge clk);
        rst = r; issue_valid = v;
        issue_src_a = 5'(sa); issue_use_a = ua;
        issue_src_b = 5'(sb); issue_use_b = ub;
        issue_dst = 5'(dst); issue_wr = wr; issue_lat = 2'(lat);
        wb_valid = wbv; wb_add = 5'(wba);
        #1;
        chk("model_ready", int'(issue_ready), int'(m_ready()));
        chk("model_fwd_a", int'(fwd_sel_a), m_fwd(issue_use_a, issue_src_a));
        chk("model_fwd_b", int'(fwd_sel_b), m_fwd(issue_use_b, issue_src_b));
        chk("model_stall", int'(stall_cycles), perf_en ? m_stall : 0);
    endtask

    task automatic tick();
        bit rdy;
        @(posedge clk);
        rdy = m_ready();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
            m_stall = 0;
        end else begin
            if (wb_valid && wb_add != 0) m_pend[wb_add] = 0;
            if (issue_valid && rdy && issue_wr && issue_dst != 0) begin
                m_pend[issue_dst]  = 1;
                m_itime[issue_dst] = now;
                m_need[issue_dst]  = (issue_lat == 2'd1) ? 1 : 2;
            end
            if (issue_valid && !rdy && m_stall != 16'hFFFF) m_stall++;
        end
        now++;
    endtask

    task automatic idle_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ready", int'(issue_ready), 1);
        chk("reset_fwd_a", int'(fwd_sel_a), 0);
        chk("reset_fwd_b", int'(fwd_sel_b), 0);
        chk("reset_stall", int'(stall_cycles), 0);
        tick();
    endtask

    initial begin
`ifdef HAZARD_SCOREBOARD_PERF_EN
        perf_en = 1;
`else
        perf_en = 0;
`endif
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0; m_itime[i] = 0; m_need[i] = 0;
        end
        rst = 1; issue_valid = 0; issue_src_a = 0; issue_src_b = 0;
        issue_use_a = 0; issue_use_b = 0; issue_dst = 0; issue_wr = 0;
        issue_lat = 0; wb_valid = 0; wb_add = 0;
        idle_reset();

        // ALU producer forwards from EXE/MEM the very next cycle.
        drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("alu_ready", int'(issue_ready), 1);
        chk("alu_fwd_a", int'(fwd_sel_a), 1);
        tick();

        // Load-use: one stall cycle, then forward from MEM/WB.
        idle_reset();
        drive(0, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0); tick();
        drive(0, 1, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        chk("load_stall_ready", int'(issue_ready), 0);
        tick();
        drive(0, 1, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        chk("load_ready", int'(issue_ready), 1);
        chk("load_fwd_b", int'(fwd_sel_b), 2);
        chk("load_stall_cnt", int'(stall_cycles), perf_en ? 1 : 0);
        tick();

        // WAW blocks until the older write retires; same-cycle retire is not bypassed.
        drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        chk("waw_ready_0", int'(issue_ready), 0); tick();
        drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 1, 3);
        chk("waw_ready_wb", int'(issue_ready), 0); tick();
        drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        chk("waw_ready_after", int'(issue_ready), 1); tick();

        // Set beats same-cycle retire of the same register.
        idle_reset();
        drive(0, 1, 0, 0, 0, 0, 9, 1, 2, 1, 9); tick();
        drive(0, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("setwin_ready", int'(issue_ready), 0);
        chk("setwin_fwd_a", int'(fwd_sel_a), 1);
        tick();

        // Register 0 and unused sources never hazard or forward.
        drive(0, 1, 9, 0, 9, 0, 0, 1, 2, 0, 0);
        chk("r0_ready", int'(issue_ready), 1);
        chk("r0_fwd_a", int'(fwd_sel_a), 0);
        chk("r0_fwd_b", int'(fwd_sel_b), 0);
        tick();
        drive(0, 1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        chk("r0_src_ready", int'(issue_ready), 1);
        chk("r0_src_fwd_a", int'(fwd_sel_a), 0);
        tick();

        // Reset clears several pending loads at once.
        drive(0, 1, 0, 0, 0, 0, 10, 1, 2, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 11, 1, 2, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 12, 1, 2, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 13, 1, 2, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 14, 1, 2, 1, 10); tick();
        drive(0, 1, 13, 1, 12, 1, 11, 1, 2, 0, 0);
        chk("rst_ready", int'(issue_ready), 1);
        chk("rst_fwd_a", int'(fwd_sel_a), 0);
        chk("rst_fwd_b", int'(fwd_sel_b), 0);
        tick();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 3), ($urandom_range(0, 9) < 3),
                  $urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
